// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults for the RAM-backed FIFO controller and its pointer sub-module.
package ram_fifo_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: ADDR_W address bits plus one MSB that toggles on each lap.
module fifo_ptr
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int W = DEF_ADDR_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o,
    output logic [W-1:0] ptr_nxt_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Modulo-2**W wrap falls out of the fixed-width add.
    assign ptr_d     = ptr_q + {{(W-1){1'b0}}, inc_i};
    assign ptr_o     = ptr_q;
    assign ptr_nxt_o = ptr_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a dual-port synchronous RAM: pointers, flags, fill level and
// sticky error flags; data lives in the RAM and is passed through on the read side.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data
);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] wr_ptr_nxt;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] rd_ptr_nxt;
    logic            push_acc;
    logic            pop_acc;

    logic            full_q,  full_d;
    logic            empty_q, empty_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            pop_valid_q;
    logic            overflow_q;
    logic            underflow_q;

    // Acceptance uses flags registered at the start of the cycle, so a push into an
    // empty FIFO cannot be popped in the same cycle.
    assign push_acc = push & ~full_q;
    assign pop_acc  = pop & ~empty_q;

    fifo_ptr #(.W(ADDR_W + 1)) u_wr_ptr (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (push_acc),
        .ptr_o     (wr_ptr),
        .ptr_nxt_o (wr_ptr_nxt)
    );

    fifo_ptr #(.W(ADDR_W + 1)) u_rd_ptr (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (pop_acc),
        .ptr_o     (rd_ptr),
        .ptr_nxt_o (rd_ptr_nxt)
    );

    // Flags are derived from next-state pointers so they land in flops with the pointers.
    assign empty_d = (wr_ptr_nxt == rd_ptr_nxt);
    assign full_d  = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                     (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
    assign count_d = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            empty_q     <= empty_d;
            count_q     <= count_d;
            pop_valid_q <= pop_acc;
            overflow_q  <= overflow_q | (push & full_q);
            underflow_q <= underflow_q | (pop & empty_q);
        end
    end

    assign ram_wr_en   = push_acc;
    assign ram_wr_addr = wr_ptr[ADDR_W-1:0];
    assign ram_wr_data = push_data;
    assign ram_rd_en   = pop_acc;
    assign ram_rd_addr = rd_ptr[ADDR_W-1:0];

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign pop_valid = pop_valid_q;
    assign pop_data  = ram_rd_data;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed, table-driven bench for ram_fifo_ctrl with a behavioural dual-port RAM.
module tb_ram_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              pop;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    logic [DATA_W-1:0] mem [16];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .full        (full),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    // Stand-in for dual_ram: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    typedef struct {
        logic       push;
        logic [7:0] pdata;
        logic       pop;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic       rd_en;
        logic [3:0] rd_addr;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       pvalid;
        logic [7:0] pdat;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic push_v, input logic [7:0] pdata_v, input logic pop_v,
                                input logic wr_en_v, input int wr_addr_v,
                                input logic rd_en_v, input int rd_addr_v,
                                input int count_v, input logic full_v, input logic empty_v,
                                input logic pvalid_v, input logic [7:0] pdat_v,
                                input logic ovf_v, input logic unf_v);
        vec_t v;
        v.push = push_v;   v.pdata = pdata_v;   v.pop = pop_v;
        v.wr_en = wr_en_v; v.wr_addr = 4'(wr_addr_v);
        v.rd_en = rd_en_v; v.rd_addr = 4'(rd_addr_v);
        v.count = 5'(count_v); v.full = full_v; v.empty = empty_v;
        v.pvalid = pvalid_v; v.pdat = pdat_v; v.ovf = ovf_v; v.unf = unf_v;
        return v;
    endfunction

    // Drive at the falling edge, check combinational RAM controls mid-cycle,
    // then check registered outputs just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        push = v.push; push_data = v.pdata; pop = v.pop;
        #1;
        check($sformatf("v%0d ram_wr_en", idx), 32'(ram_wr_en), 32'(v.wr_en));
        check($sformatf("v%0d ram_wr_addr", idx), 32'(ram_wr_addr), 32'(v.wr_addr));
        if (v.wr_en) check($sformatf("v%0d ram_wr_data", idx), 32'(ram_wr_data), 32'(v.pdata));
        check($sformatf("v%0d ram_rd_en", idx), 32'(ram_rd_en), 32'(v.rd_en));
        check($sformatf("v%0d ram_rd_addr", idx), 32'(ram_rd_addr), 32'(v.rd_addr));
        @(posedge clk);
        #1;
        check($sformatf("v%0d count", idx), 32'(count), 32'(v.count));
        check($sformatf("v%0d full", idx), 32'(full), 32'(v.full));
        check($sformatf("v%0d empty", idx), 32'(empty), 32'(v.empty));
        check($sformatf("v%0d pop_valid", idx), 32'(pop_valid), 32'(v.pvalid));
        if (v.pvalid) check($sformatf("v%0d pop_data", idx), 32'(pop_data), 32'(v.pdat));
        check($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.ovf));
        check($sformatf("v%0d underflow", idx), 32'(underflow), 32'(v.unf));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " empty"}, 32'(empty), 32'd1);
        check({tag, " full"}, 32'(full), 32'd0);
        check({tag, " count"}, 32'(count), 32'd0);
        check({tag, " pop_valid"}, 32'(pop_valid), 32'd0);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " underflow"}, 32'(underflow), 32'd0);
        check({tag, " ram_wr_en"}, 32'(ram_wr_en), 32'd0);
        check({tag, " ram_rd_en"}, 32'(ram_rd_en), 32'd0);
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("idle");

        // Fill 0x10..0x1F; 16th push raises full.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 8'(8'h10 + i), 0, 1, i, 0, 0, i + 1, i == 15, 0, 0, 8'h00, 0, 0));
        // Push+pop while full: push rejected, overflow, count 15, first word out.
        vecs.push_back(mk(1, 8'hA5, 1, 0, 0, 1, 0, 15, 0, 0, 1, 8'h10, 1, 0));
        // Drain the remaining 15 words in order.
        for (int j = 1; j < 16; j++)
            vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, j, 15 - j, 0, j == 15, 1, 8'(8'h10 + j), 1, 0));
        // Push+pop while empty: push accepted at addr 0 (wr_ptr=16), pop rejected.
        vecs.push_back(mk(1, 8'h77, 1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 1, 1, 8'h77, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 1, 0, 8'h00, 1, 1));

        foreach (vecs[k]) apply(vecs[k], k);

        // Wrap: prime 3 words, then 40 push/pop pairs keep the level at 3.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            push = 1'b1; push_data = 8'(8'h80 + k); pop = 1'b0;
        end
        @(posedge clk);
        #1;
        check("wrap prime count", 32'(count), 32'd3);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            push = 1'b1; push_data = 8'(8'h83 + n); pop = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d pop_valid", n), 32'(pop_valid), 32'd1);
            check($sformatf("wrap%0d pop_data", n), 32'(pop_data), 32'(8'(8'h80 + n)));
            check($sformatf("wrap%0d count", n), 32'(count), 32'd3);
            check($sformatf("wrap%0d full", n), 32'(full), 32'd0);
            check($sformatf("wrap%0d empty", n), 32'(empty), 32'd0);
        end

        // Async reset mid-burst with pop_valid high.
        @(negedge clk);
        push = 1'b0; pop = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset pop_valid", 32'(pop_valid), 32'd1);
        check("pre-reset pop_data", 32'(pop_data), 32'h0A8);
        #1;
        rst = 1'b0;
        #1;
        check_reset_state("async reset");
        @(negedge clk);
        pop = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives the write and read ports of the team's dual-port synchronous RAM (dual_ram). It turns the RAM into a FIFO.
- Upstream producer side: push/full handshake.
- Downstream consumer side: pop/empty/valid handshake.
- Generates RAM addresses and enables, and tracks fill level and error flags.
- Holds no data storage itself; all data lives in the RAM.

Parameters:
DATA_W, 8, width of data words (matches RAM word width)
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W = 16

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
push  input  1  producer requests write of push_data
push_data  input  DATA_W  word to enqueue
full  output  1  FIFO holds 2**ADDR_W words
pop  input  1  consumer requests a word
pop_data  output  DATA_W  dequeued word, meaningful only when pop_valid=1
pop_valid  output  1  pop_data valid this cycle
empty  output  1  FIFO holds 0 words
count  output  ADDR_W+1  current fill level, 0..2**ADDR_W
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty
ram_wr_en  output  1  RAM write-port enable
ram_wr_addr  output  ADDR_W  RAM write address
ram_wr_data  output  DATA_W  RAM write data
ram_rd_en  output  1  RAM read-port enable
ram_rd_addr  output  ADDR_W  RAM read address
ram_rd_data  input  DATA_W  RAM read data; valid 1 cycle after ram_rd_en

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. While rst=0, all state is cleared immediately, independent of clk.
- Reset values:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0.
  - pop_valid=0, overflow=0, underflow=0.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits. The MSB is a wrap bit.
  - ram_wr_addr = wr_ptr[ADDR_W-1:0]; ram_rd_addr = rd_ptr[ADDR_W-1:0].
  - Pointers increment modulo 2**(ADDR_W+1); wrap from 31 to 0 is silent.
- Flags and count, all registered outputs:
  - empty = (wr_ptr == rd_ptr).
  - full = (addresses equal AND wrap bits differ).
  - count = wr_ptr - rd_ptr, computed in ADDR_W+1 bits.
- Push acceptance: push_acc = push & ~full, using full as registered at the start of the cycle.
  - ram_wr_en = push_acc (combinational); ram_wr_data = push_data.
  - wr_ptr advances on the clock edge when push_acc=1.
- Pop acceptance: pop_acc = pop & ~empty.
  - ram_rd_en = pop_acc (combinational); rd_ptr advances on the clock edge when pop_acc=1.
  - pop_valid is pop_acc delayed one cycle; pop_data = ram_rd_data, passed through.
  - Latency from pop to data is exactly 1 cycle.
- Simultaneous push & pop:
  - Neither full nor empty: both accepted; count unchanged; full/empty unchanged.
  - Full: pop accepted, push rejected, overflow set. Count drops to 15 next cycle.
  - Empty: push accepted, pop rejected, underflow set. Count rises to 1 next cycle.
  - A word pushed into an empty FIFO is first poppable on the following cycle, so there is no write-to-read bypass.
- Errors: overflow and underflow set on a rejected push or pop. They are cleared only by reset.
- Reset mid-operation: an in-flight pop_valid is dropped. RAM contents are not cleared but are treated as stale.
- Back-to-back: one push and one pop per cycle are sustainable indefinitely.

Decomposition:
- Shared include file fifo_defs.vh holds:
  - default DATA_W and ADDR_W;
  - localparam DEPTH = 1<<ADDR_W.
- One natural sub-module, fifo_ptr: an ADDR_W+1-bit pointer with increment enable and async active-low reset. It is instantiated twice, for write and read.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, pop_valid=0, ram_wr_en=0, ram_rd_en=0.
- Push 16 words 0x10..0x1F on consecutive cycles → full=1 after the 16th edge; count=16; ram_wr_addr runs 0..15.
- From full: pop 16 times → pop_data 0x10..0x1F, each 1 cycle after pop; empty=1 after the last pop; count=0.
- Simultaneous push 0xA5 + pop at count=16 → push rejected, overflow=1, count=15. Simultaneous push + pop at count=0 → push accepted, underflow=1, count=1.
- Wrap test: 40 push/pop pairs with count held at 3 → data order preserved across pointer wrap; full and empty never assert.
- Assert rst=0 asynchronously mid-burst while pop_valid=1 → all outputs return to reset values before the next clk edge.
